pwm_duty_ctrl: RTL and testbench
================================

Name: pwm_duty_ctrl

Overview:
- Fixed-period PWM generator whose duty cycle is stepped up/down by two push-button style inputs (inc, dec).
- Button inputs are asynchronous and bouncy. The block synchronizes and debounces them, then acts once per press.
- Sits between user controls (buttons/GPIO) and a PWM-driven load (LED, motor driver).

Parameters:
- PERIOD, 10, PWM period in clk cycles (>=2).
- INIT_DUTY, 5, duty (high cycles per period) loaded at reset; must be 0..PERIOD.
- STEP, 1, duty change per accepted press (>=1).
- DEB_CYCLES, 3, consecutive stable synchronized samples required to accept a level change on inc/dec (>=1).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- inc  input  1  asynchronous button; a press (low->high) raises duty by STEP.
- dec  input  1  asynchronous button; a press lowers duty by STEP.
- pwm_out  output  1  registered PWM output.

Behaviour:
- Reset (rst_n=0, async, immediate):
  - cnt=0; duty=duty_active=INIT_DUTY; pwm_out=0.
  - Synchronizers, debounce counters and debounced levels cleared to 0.
  - Release is sampled on the next clk rising edge.
- Counter widths: cnt width $clog2(PERIOD); duty width $clog2(PERIOD+1).
- Input path, independent per button:
  - 2-flop synchronizer, then debounce.
  - Debounced level changes only after the synced value differs from it for DEB_CYCLES consecutive clocks. Any mismatch-free sample resets the debounce count.
  - Rising edge of the debounced level produces a one-cycle press strobe.
  - Falling edges and held-high levels produce nothing (no auto-repeat).
  - Strobe appears no later than 2+DEB_CYCLES+1 clocks after a clean input rise.
- Duty update, on a strobe cycle:
  - inc only: duty = min(duty+STEP, PERIOD), saturating; no wrap.
  - dec only: duty = max(duty-STEP, 0), saturating; no wrap/underflow.
  - Both strobes in the same cycle: duty unchanged.
- Counter:
  - cnt increments every clock, 0..PERIOD-1, then wraps to 0.
  - When cnt==PERIOD-1, duty_active <= duty (shadow load). Duty changes therefore take effect only at period boundaries, with no mid-period glitch.
- Output:
  - pwm_out <= (cnt < duty_active), registered, one clock behind cnt.
  - duty_active=0: constant 0. duty_active=PERIOD: constant 1.
  - Otherwise exactly duty_active high cycles followed by PERIOD-duty_active low cycles per period. High phase starts one clock after cnt==0.
- Reset asserted mid-period or mid-press:
  - All state returns to reset values immediately.
  - A button still held at reset release counts as a new press once debounced (debounced level restarts at 0).

Test Plan:
- Reset then idle 40 clocks -> pwm_out period 10; each period exactly 5 clocks high, 5 low; pwm_out=0 during reset.
- inc high for 10 clocks, then low -> exactly one step. duty=6; from the next period boundary, 6 high / 4 low; no further change while held.
- After previous, dec high for 5 clocks -> duty back to 5; waveform returns to 5/5 at the next period boundary.
- inc glitch of 2 clocks (shorter than DEB_CYCLES after sync) -> no duty change. Bouncy 1-0-1 within 2 clocks followed by 10 clocks high -> exactly one step.
- 7 clean inc presses from 5 -> duty saturates at 10, pwm_out constantly 1. Then 12 dec presses -> duty 0, pwm_out constantly 0, no wrap.
- inc and dec driven identically and simultaneously -> duty unchanged. rst_n pulsed low mid-period at duty 8 -> pwm_out=0 at once, duty back to 5 after release.

Source files
------------

// File: rtl/pwm_duty_ctrl.sv
// rtl/pwm_duty_ctrl.sv - fixed-period PWM whose duty is stepped by two debounced buttons.
// Duty edits land in a shadow register that is copied to duty_active only at period wrap.
module pwm_duty_ctrl #(
  parameter int PERIOD     = 10,
  parameter int INIT_DUTY  = 5,
  parameter int STEP       = 1,
  parameter int DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic pwm_out
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DW = $clog2(PERIOD + 1);
  localparam int BW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  // Bit 0 carries inc, bit 1 carries dec.
  logic [1:0]         raw;
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         lvl;
  logic [1:0]         lvl_d;
  logic [1:0][BW-1:0] deb_cnt;
  logic [1:0]         press;

  logic [CW-1:0]      cnt;
  logic [DW-1:0]      duty;
  logic [DW-1:0]      duty_active;
  logic [DW-1:0]      duty_next;

  assign raw   = {dec, inc};
  assign press = lvl & ~lvl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      lvl     <= '0;
      lvl_d   <= '0;
      deb_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl_d <= lvl;
      // A level flips only after DEB_CYCLES back-to-back disagreeing samples.
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != lvl[i]) begin
          if (deb_cnt[i] == BW'(DEB_CYCLES - 1)) begin
            lvl[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    duty_next = duty;
    if (press[0] && !press[1]) begin
      duty_next = (int'(duty) + STEP >= PERIOD) ? DW'(PERIOD) : DW'(int'(duty) + STEP);
    end else if (press[1] && !press[0]) begin
      duty_next = (int'(duty) <= STEP) ? '0 : DW'(int'(duty) - STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      duty        <= DW'(INIT_DUTY);
      duty_active <= DW'(INIT_DUTY);
      pwm_out     <= 1'b0;
    end else begin
      duty <= duty_next;
      if (cnt == CW'(PERIOD - 1)) begin
        cnt         <= '0;
        duty_active <= duty;
      end else begin
        cnt <= cnt + 1'b1;
      end
      pwm_out <= (DW'(cnt) < duty_active);
    end
  end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb/tb_pwm_duty_ctrl.sv - scoreboard bench: expected duty per action, monitor checks a full PWM period.
module tb_pwm_duty_ctrl;

  localparam int PERIOD     = 10;
  localparam int INIT_DUTY  = 5;
  localparam int STEP       = 1;
  localparam int DEB_CYCLES = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inc = 1'b0;
  logic dec = 1'b0;
  logic pwm_out;

  int n_tests = 0;
  int n_fail  = 0;
  int model_duty;
  int exp_q[$];
  int cyc;

  always #5 clk = ~clk;

  pwm_duty_ctrl #(
    .PERIOD(PERIOD), .INIT_DUTY(INIT_DUTY), .STEP(STEP), .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .pwm_out(pwm_out)
  );

  // cyc = number of rising edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: once an expectation is queued, capture the next whole output period and compare.
  initial begin : monitor
    bit armed;
    bit meas;
    int arm_cyc;
    int idx;
    int d;
    logic [PERIOD-1:0] vec;
    logic [PERIOD-1:0] exp_vec;
    armed = 0; meas = 0; arm_cyc = 0; idx = 0; d = 0; vec = '0; exp_vec = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        armed = 0;
        meas  = 0;
      end else begin
        if (meas) begin
          vec[idx] = pwm_out;
          idx++;
          if (idx == PERIOD) begin
            d = exp_q.pop_front();
            exp_vec = '0;
            for (int i = 0; i < PERIOD; i++) if (i < d) exp_vec[i] = 1'b1;
            n_tests++;
            if (vec !== exp_vec) begin
              n_fail++;
              $display("FAIL period_shape duty=%0d got %b want %b", d, vec, exp_vec);
            end
            meas  = 0;
            armed = 0;
          end
        end else if (!armed && exp_q.size() > 0) begin
          armed   = 1;
          arm_cyc = cyc;
        end
        if (armed && !meas && (cyc % PERIOD) == 1 && cyc >= arm_cyc + 2) begin
          meas   = 1;
          vec    = '0;
          vec[0] = pwm_out;
          idx    = 1;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int step_model(input int d, input bit up, input bit down);
    if (up && !down) return (d + STEP > PERIOD) ? PERIOD : d + STEP;
    if (down && !up) return (d - STEP < 0) ? 0 : d - STEP;
    return d;
  endfunction

  task automatic expect_duty();
    int t;
    exp_q.push_back(model_duty);
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout pending got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Long holds are also checked while still held, so auto-repeat would show up.
  task automatic press(input bit up, input bit down, input bit bouncy, input int hold);
    if (bouncy) begin
      inc = up; dec = down; tick(1);
      inc = 0;  dec = 0;    tick(1);
    end
    inc = up; dec = down;
    if (hold >= 12) begin
      tick(12);
      model_duty = step_model(model_duty, up, down);
      expect_duty();
    end else begin
      tick(hold);
    end
    inc = 0; dec = 0;
    tick(12);
    if (hold < 12) model_duty = step_model(model_duty, up, down);
    expect_duty();
  endtask

  task automatic glitch(input int len);
    inc = 1; tick(len);
    inc = 0; tick(12);
    expect_duty();
  endtask

  initial begin : stim
    int kind;
    rst_n = 1'b0;
    tick(3);
    #1 check("reset_pwm", pwm_out, 0);
    rst_n = 1'b1;
    model_duty = INIT_DUTY;
    for (int k = 0; k < 3; k++) expect_duty();

    press(1, 0, 0, 10);
    press(0, 1, 0, 5);
    press(1, 0, 0, 40);
    press(0, 1, 0, 5);
    glitch(2);
    glitch(1);
    press(1, 0, 1, 10);

    for (int k = 0; k < 7; k++)  press(1, 0, 0, 8);
    for (int k = 0; k < 12; k++) press(0, 1, 0, 8);
    for (int k = 0; k < 8; k++)  press(1, 0, 0, 6);
    press(1, 1, 0, 10);
    press(1, 1, 1, 14);

    for (int t = 0; t < 20 && (cyc % PERIOD) != 4; t++) tick(1);
    check("pwm_high_before_reset", pwm_out, 1);
    rst_n = 1'b0;
    #1 check("reset_mid_period_pwm", pwm_out, 0);
    tick(2);
    rst_n = 1'b1;
    model_duty = INIT_DUTY;
    expect_duty();

    inc = 1;
    tick(3);
    rst_n = 1'b0;
    #1 check("reset_mid_press_pwm", pwm_out, 0);
    tick(2);
    rst_n = 1'b1;
    model_duty = INIT_DUTY;
    tick(12);
    model_duty = step_model(model_duty, 1, 0);
    expect_duty();
    inc = 0;
    tick(12);
    expect_duty();

    for (int k = 0; k < 25; k++) begin
      kind = $urandom_range(0, 3);
      if (kind == 3) glitch($urandom_range(1, 2));
      else press(kind != 1, kind != 0, 1'($urandom_range(0, 1)), $urandom_range(5, 14));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
